// File: rtl/lr_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lr_shift_pkg
// Description : Shared mode encoding for the left/right shift register.
// Revision    : 1.0 - initial release
// ============================================================================
package lr_shift_pkg;

    typedef logic [1:0] mode_t;

    // Encoding is {L,R} taken straight from the request pins.
    localparam mode_t MODE_LOAD     = 2'b00;
    localparam mode_t MODE_SHR      = 2'b01;
    localparam mode_t MODE_SHL      = 2'b10;
    localparam mode_t MODE_CONFLICT = 2'b11;

    function automatic logic is_load_mode(input mode_t mode);
        return (mode == MODE_LOAD) || (mode == MODE_CONFLICT);
    endfunction

endpackage : lr_shift_pkg
`default_nettype wire

// File: rtl/lr_shift_if.sv
`default_nettype none
// ============================================================================
// Module      : lr_shift_if
// Description : Control/data bundle between a shift-register driver and the register.
// Revision    : 1.0 - initial release
// ============================================================================
interface lr_shift_if #(
    parameter int WIDTH = 8
);

    logic             Si;
    logic             L;
    logic             R;
    logic [WIDTH-1:0] In;
    logic [WIDTH-1:0] Out;

    modport master (
        output Si,
        output L,
        output R,
        output In,
        input  Out
    );

    modport slave (
        input  Si,
        input  L,
        input  R,
        input  In,
        output Out
    );

endinterface : lr_shift_if
`default_nettype wire

// File: rtl/lr_shift_next.sv
`default_nettype none
// ============================================================================
// Module      : lr_shift_next
// Description : Combinational next-state select: load, shift right or shift left.
// Revision    : 1.0 - initial release
// ============================================================================
module lr_shift_next
    import lr_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire mode_t            i_mode,
    input  wire logic             i_si,
    input  wire logic [WIDTH-1:0] i_in,
    input  wire logic [WIDTH-1:0] i_state,
    output logic      [WIDTH-1:0] o_next
);

    always_comb begin
        o_next = i_in;
        case (i_mode)
            MODE_SHR:      o_next = {i_si, i_state[WIDTH-1:1]};
            MODE_SHL:      o_next = {i_state[WIDTH-2:0], i_si};
            // A conflicting request falls back to a parallel load.
            MODE_LOAD,
            MODE_CONFLICT: o_next = i_in;
            default:       o_next = i_in;
        endcase
    end

endmodule : lr_shift_next
`default_nettype wire

// File: rtl/lr_shift_1.sv
`default_nettype none
// ============================================================================
// Module      : lr_shift_1
// Description : Loadable left/right shift register with serial input.
// Revision    : 1.0 - initial release
// ============================================================================
module lr_shift_1
    import lr_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    lr_shift_if.slave   bus
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;
    mode_t            w_mode;

    assign w_mode = {bus.L, bus.R};

    lr_shift_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_mode  (w_mode),
        .i_si    (bus.Si),
        .i_in    (bus.In),
        .i_state (r_state),
        .o_next  (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else begin
            r_state <= w_next;
        end
    end

    assign bus.Out = r_state;

endmodule : lr_shift_1
`default_nettype wire

// File: tb/tb_lr_shift_1.sv
`default_nettype none
// ============================================================================
// Module      : tb_lr_shift_1
// Description : Directed self-checking bench for lr_shift_1 (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lr_shift_1;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    lr_shift_if #(.WIDTH(WIDTH)) bus ();

    lr_shift_1 #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] expected);
        checks++;
        assert (bus.Out === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, bus.Out, expected);
        end
    endtask

    task automatic drive(input logic l, input logic r, input logic si, input logic [WIDTH-1:0] din);
        bus.L  = l;
        bus.R  = r;
        bus.Si = si;
        bus.In = din;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'hFF);
        #1;
        check("reset_immediate", 8'h00);
        step();
        check("reset_held_1", 8'h00);
        step();
        check("reset_held_2", 8'h00);

        rst_n = 1'b1;
        step();
        check("load_ff", 8'hFF);

        drive(1'b0, 1'b1, 1'b0, 8'hA5);
        step();
        check("shr_si0_a", 8'h7F);
        step();
        check("shr_si0_b", 8'h3F);

        drive(1'b1, 1'b0, 1'b0, 8'h5A);
        step();
        check("shl_si0_a", 8'h7E);
        step();
        check("shl_si0_b", 8'hFC);

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        step();
        check("load_00_si1", 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        step();
        check("shr_si1", 8'h80);

        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        check("load_00", 8'h00);
        drive(1'b1, 1'b0, 1'b1, 8'hFF);
        step();
        check("shl_si1", 8'h01);

        drive(1'b1, 1'b1, 1'b1, 8'hAA);
        step();
        check("conflict_si1", 8'hAA);
        drive(1'b1, 1'b1, 1'b0, 8'hAA);
        step();
        check("conflict_si0", 8'hAA);
        drive(1'b0, 1'b0, 1'b0, 8'h55);
        step();
        check("load55_si0", 8'h55);
        drive(1'b0, 1'b0, 1'b1, 8'h55);
        step();
        check("load55_si1", 8'h55);

        // Bits shifted off either end are lost, never wrapped.
        drive(1'b0, 1'b0, 1'b0, 8'h01);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'hFF);
        step();
        check("shr_no_wrap", 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h80);
        step();
        drive(1'b1, 1'b0, 1'b0, 8'hFF);
        step();
        check("shl_no_wrap", 8'h00);

        drive(1'b0, 1'b0, 1'b0, 8'hFF);
        step();
        check("mid_load_ff", 8'hFF);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        check("mid_shr", 8'h7F);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", 8'h00);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        step();
        check("post_reset_shr_si1", 8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_lr_shift_1
`default_nettype wire

// File: doc/lr_shift_1.md
LR_SHIFT_1 -- requirements
Module: lr_shift_1

Interface
REQ-001 The module SHALL have exactly one parameter: WIDTH, default 8, register width in bits (legal range 2 to 64).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port Si, input, 1 bit: serial-in bit inserted on a shift.
REQ-005 The module SHALL have port L, input, 1 bit: shift-left request.
REQ-006 The module SHALL have port R, input, 1 bit: shift-right request.
REQ-007 The module SHALL have port In, input, WIDTH bits: parallel load data.
REQ-008 The module SHALL have port Out, output, WIDTH bits: registered register contents.

Function
REQ-009 The mode SHALL be decoded from {L,R} on each rising clk edge while rst_n is high.
REQ-010 {L,R}=00: Out SHALL load In (parallel load).
REQ-011 {L,R}=01: Out SHALL become {Si, Out[WIDTH-1:1]} (logical shift right; Si enters the MSB; the LSB is discarded).
REQ-012 {L,R}=10: Out SHALL become {Out[WIDTH-2:0], Si} (shift left; Si enters the LSB; the MSB is discarded).
REQ-013 {L,R}=11 (conflicting request): Out SHALL load In, identical to 00; neither shift direction takes priority.
REQ-014 Latency SHALL be one clock: the result of a mode sampled at edge N is visible on Out immediately after edge N.
REQ-015 There SHALL be no hold mode; every enabled edge either loads or shifts.
REQ-016 Out SHALL be driven directly from the state flops, with no combinational path from any input to Out.
REQ-017 Si SHALL be ignored in load modes (00 and 11).
REQ-018 In SHALL be ignored in shift modes (01 and 10).
REQ-019 Repeated shifts SHALL NOT wrap around; a bit shifted out is lost.
REQ-020 X or Z on L or R is outside scope; the design need not define Out for those inputs.

Reset
REQ-021 While rst_n is low, Out SHALL be all zeros, asynchronously and independent of clk.
REQ-022 A reset asserted mid-sequence SHALL immediately clear Out and discard any pending shift.
REQ-023 On the first rising clk edge after rst_n deasserts, the register SHALL resume normal decoding per REQ-010 to REQ-013.

Structure
REQ-024 A shared package lr_shift_pkg SHALL hold the 2-bit mode encoding constants: MODE_LOAD=00, MODE_SHR=01, MODE_SHL=10, MODE_CONFLICT=11.
REQ-025 The next-state selection SHALL be a combinational sub-module, lr_shift_next, with inputs mode, Si, In and current state, and output next state.
REQ-026 The top level SHALL contain only the reset flop bank and the instance of lr_shift_next.

Verification
REQ-027 Reset scenario: assert rst_n=0 with In=0xFF and {L,R}=00 -> Out=0x00 immediately and for as long as reset is held.
REQ-028 Load scenario: after reset, apply In=0xFF with {L,R}=00 for one edge -> Out=0xFF.
REQ-029 Shift-right scenario: from Out=0xFF, apply {L,R}=01 with Si=0 -> Out=0x7F, then 0x3F on the next edge; with Si=1 from Out=0x00 -> Out=0x80.
REQ-030 Shift-left scenario: from Out=0x3F, apply {L,R}=10 with Si=0 -> Out=0x7E, then 0xFC; with Si=1 from Out=0x00 -> Out=0x01.
REQ-031 Conflict and default scenario: apply {L,R}=11 with In=0xAA -> Out=0xAA; then {L,R}=00 with In=0x55 -> Out=0x55; Si toggling in either case has no effect.
REQ-032 Mid-operation reset scenario: during a run of shifts from 0xFF, pulse rst_n low between edges -> Out=0x00 at once; the next edge with {L,R}=01 and Si=1 -> Out=0x80.
